// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register.
//   DATA_W / ADDR_W / CTRL_W : datapath, register-address and control widths
//   REG_ZERO                 : hard-wired zero register; never forwarded
//   CTRL_*                   : bit positions of fields inside the control bundle
package id_ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CTRL_W = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'h0;

  // Control bundle layout: [3:0] alu_op, [4] regWrite, [5] memRead, [6] memWrite.
  localparam int CTRL_ALU_OP_LSB   = 0;
  localparam int CTRL_ALU_OP_W     = 4;
  localparam int CTRL_REGWRITE_BIT = 4;
  localparam int CTRL_MEMREAD_BIT  = 5;
  localparam int CTRL_MEMWRITE_BIT = 6;

  function automatic logic [CTRL_ALU_OP_W-1:0] ctrl_alu_op(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_ALU_OP_LSB +: CTRL_ALU_OP_W];
  endfunction

  function automatic logic ctrl_reg_write(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE_BIT];
  endfunction

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD_BIT];
  endfunction

  function automatic logic ctrl_mem_write(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMWRITE_BIT];
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding selector.
//   addr / rf_data     : source register address and the register-file value
//   ex_en/addr/data    : execute-stage result about to be written
//   wb_en/addr/data    : writeback-stage result being written this cycle
//   operand            : selected value (zero register always reads as zero;
//                        EX beats WB beats the register file)
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_en,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (addr == AW'(REG_ZERO)) begin
      operand = '0;
    end else if (ex_en && (ex_addr == addr)) begin
      operand = ex_data;
    end else if (wb_en && (wb_addr == addr)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX->ID and WB->ID operand forwarding.
//   CLK, Reset_n        : rising-edge clock, asynchronous active-low reset
//   Stall, Flush        : hold contents / insert bubble (Flush wins)
//   in_valid, Read1..3, Data1..3, in_imm, in_ctrl : decode-slot contents
//   ex_fwd_*            : execute-stage result for forwarding
//   wb_regWrite/addr/data : writeback result for forwarding
//   ex_valid, ex_A/B/C, ex_src1..3, ex_imm, ex_ctrl : registered execute slot
//
// Flow control: every output is a flop. On each rising edge, Flush turns the
// slot into a bubble (ex_valid=0, ex_ctrl=0, rest held); otherwise Stall holds
// the slot, only refreshing a held operand whose source register is being
// written back; otherwise the slot loads, with ex_valid taking in_valid and
// ex_ctrl forced to zero for a non-valid slot.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W,
  parameter int CW = CTRL_W
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          in_valid,
  input  logic [AW-1:0] Read1,
  input  logic [AW-1:0] Read2,
  input  logic [AW-1:0] Read3,
  input  logic [DW-1:0] Data1,
  input  logic [DW-1:0] Data2,
  input  logic [DW-1:0] Data3,
  input  logic [DW-1:0] in_imm,
  input  logic [CW-1:0] in_ctrl,
  input  logic          ex_fwd_en,
  input  logic [AW-1:0] ex_fwd_addr,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          wb_regWrite,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_A,
  output logic [DW-1:0] ex_B,
  output logic [DW-1:0] ex_C,
  output logic [AW-1:0] ex_src1,
  output logic [AW-1:0] ex_src2,
  output logic [AW-1:0] ex_src3,
  output logic [DW-1:0] ex_imm,
  output logic [CW-1:0] ex_ctrl
);

  logic [AW-1:0] rd_addr [3];
  logic [DW-1:0] rd_data [3];
  logic [DW-1:0] load_op [3];
  logic [DW-1:0] hold_op [3];

  logic          valid_q, valid_d;
  logic [DW-1:0] op_q  [3];
  logic [DW-1:0] op_d  [3];
  logic [AW-1:0] src_q [3];
  logic [AW-1:0] src_d [3];
  logic [DW-1:0] imm_q, imm_d;
  logic [CW-1:0] ctrl_q, ctrl_d;

  assign rd_addr[0] = Read1;
  assign rd_addr[1] = Read2;
  assign rd_addr[2] = Read3;
  assign rd_data[0] = Data1;
  assign rd_data[1] = Data2;
  assign rd_data[2] = Data3;

  for (genvar n = 0; n < 3; n++) begin : g_port
    // Operand selected when the slot loads.
    id_ex_stage_fwd_mux #(.DW(DW), .AW(AW)) u_load_mux (
      .addr    (rd_addr[n]),
      .rf_data (rd_data[n]),
      .ex_en   (ex_fwd_en),
      .ex_addr (ex_fwd_addr),
      .ex_data (ex_fwd_data),
      .wb_en   (wb_regWrite),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .operand (load_op[n])
    );

    // Operand kept while stalled: the EX producer is stalled too, so only a
    // writeback into the held source register may update it, and only for a
    // real instruction.
    id_ex_stage_fwd_mux #(.DW(DW), .AW(AW)) u_hold_mux (
      .addr    (src_q[n]),
      .rf_data (op_q[n]),
      .ex_en   (1'b0),
      .ex_addr ('0),
      .ex_data ('0),
      .wb_en   (valid_q & wb_regWrite),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .operand (hold_op[n])
    );
  end

  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    for (int n = 0; n < 3; n++) begin
      op_d[n]  = op_q[n];
      src_d[n] = src_q[n];
    end

    if (Flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (Stall) begin
      for (int n = 0; n < 3; n++) begin
        op_d[n] = hold_op[n];
      end
    end else begin
      valid_d = in_valid;
      imm_d   = in_imm;
      ctrl_d  = in_valid ? in_ctrl : '0;
      for (int n = 0; n < 3; n++) begin
        op_d[n]  = load_op[n];
        src_d[n] = rd_addr[n];
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      for (int n = 0; n < 3; n++) begin
        op_q[n]  <= '0;
        src_q[n] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      for (int n = 0; n < 3; n++) begin
        op_q[n]  <= op_d[n];
        src_q[n] <= src_d[n];
      end
    end
  end

  assign ex_valid = valid_q;
  assign ex_A     = op_q[0];
  assign ex_B     = op_q[1];
  assign ex_C     = op_q[2];
  assign ex_src1  = src_q[0];
  assign ex_src2  = src_q[1];
  assign ex_src3  = src_q[2];
  assign ex_imm   = imm_q;
  assign ex_ctrl  = ctrl_q;

endmodule
